sobel_filter: RTL
=================

SOBEL_FILTER -- requirements
Module: sobel_filter

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 8: pixels per row, minimum 3.
REQ-002 SHALL have parameter IMG_HEIGHT, default 8: rows per frame, minimum 3.
REQ-003 SHALL have port clk_i, input, 1: the single clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port rst_i, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have port Start_i, input, 1: one-cycle pulse that begins a frame.
REQ-006 SHALL have port GrayValid_i, input, 1: upstream gray pixel is valid.
REQ-007 SHALL have port GrayColor_i, input, 8: gray pixel value, raster order.
REQ-008 SHALL have port GrayReady_o, output, 1: block accepts a pixel this cycle.
REQ-009 SHALL have port EdgeValid_o, output, 1: edge pixel is valid.
REQ-010 SHALL have port EdgeColor_o, output, 8: edge magnitude, saturated.
REQ-011 SHALL have port EdgeReady_i, input, 1: downstream accepts the edge pixel.
REQ-012 SHALL have port Done_o, output, 1: one-cycle pulse at frame completion.

Function
REQ-013 SHALL implement an FSM with states IDLE, FILL, PROCESS and DONE.
REQ-014 SHALL go IDLE->FILL on Start_i; Start_i outside IDLE SHALL be ignored.
REQ-015 SHALL accept a pixel only on a cycle with GrayValid_i=1 and GrayReady_o=1.
REQ-016 SHALL hold GrayReady_o at 0 in IDLE and DONE.
REQ-017 SHALL drive GrayReady_o in FILL/PROCESS as (!EdgeValid_o || EdgeReady_i).
REQ-018 SHALL track each accepted pixel with counters col (0..IMG_WIDTH-1, wraps to 0 and increments row) and row (0..IMG_HEIGHT-1).
REQ-019 SHALL go FILL->PROCESS when the pixel at row=1, col=IMG_WIDTH-1 is accepted.
REQ-020 SHALL go PROCESS->DONE when the pixel at row=IMG_HEIGHT-1, col=IMG_WIDTH-1 is accepted.
REQ-021 SHALL keep two line buffers of IMG_WIDTH x 8 bits plus a 3x3 window, all shifting once per accepted pixel.
REQ-022 SHALL form a window for each accepted pixel with row>=2 and col>=2, holding rows row-2..row and cols col-2..col; border centres produce no output, so a frame yields (IMG_WIDTH-2)*(IMG_HEIGHT-2) outputs.
REQ-023 SHALL compute Gx=(p02+2p12+p22)-(p00+2p10+p20), with p[r][c] and r,c relative to the window's top-left.
REQ-024 SHALL compute Gy=(p20+2p21+p22)-(p00+2p01+p02).
REQ-025 SHALL hold Gx and Gy as 11-bit signed values and |Gx|+|Gy| as 12-bit unsigned.
REQ-026 SHALL output min(|Gx|+|Gy|, 255) on EdgeColor_o.
REQ-027 SHALL load the output register and set EdgeValid_o=1 on the cycle after the accepting cycle (latency 1).
REQ-028 SHALL hold EdgeColor_o and EdgeValid_o stable while EdgeValid_o=1 and EdgeReady_i=0.
REQ-029 SHALL clear EdgeValid_o on handoff unless a new result loads in the same cycle, in which case the register reloads with no bubble.
REQ-030 SHALL, in DONE, wait until EdgeValid_o=0, then pulse Done_o for one cycle and go to IDLE.
REQ-031 SHALL clear counters on entry to FILL; line-buffer contents need no clearing.

Reset
REQ-032 SHALL, on clk_i rising with rst_i=0, set the FSM to IDLE, col=row=0, EdgeValid_o=0, EdgeColor_o=0, Done_o=0 and GrayReady_o=0.
REQ-033 SHALL let reset mid-frame abort the frame, with no Done_o pulse and no further output.

Structure
REQ-034 SHALL place COLOR_SIZE=8, GRAD_W=11, SUM_W=12 and the state encodings in shared package sobel_pkg.
REQ-035 SHALL use one sub-module, line_buffer: an enable-gated shift register, parameters COLOR_SIZE and DEPTH, instantiated twice.

Verification
REQ-036 SHALL verify: 4x4 frame, all pixels 100 -> 4 outputs, each 0, then one Done_o pulse.
REQ-037 SHALL verify: 4x4 frame, cols 0-1 = 0, cols 2-3 = 10 -> 4 outputs, each 40.
REQ-038 SHALL verify: 4x4 frame, cols 0-1 = 0, cols 2-3 = 255 -> 4 outputs, each 255 (saturated from 1020).
REQ-039 SHALL verify: EdgeReady_i held 0 for 5 cycles mid-frame -> GrayReady_o=0, EdgeColor_o stable, no output lost or duplicated.
REQ-040 SHALL verify: rst_i=0 for one cycle after 6 accepted pixels -> IDLE, all outputs 0, no Done_o; the next Start_i frame completes correctly.
REQ-041 SHALL verify: Start_i pulsed in PROCESS -> ignored; output count remains (IMG_WIDTH-2)*(IMG_HEIGHT-2).

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared widths, FSM state encoding and small arithmetic helpers for the Sobel edge filter.
package sobel_pkg;

  localparam int COLOR_SIZE = 8;
  localparam int GRAD_W     = 11;
  localparam int SUM_W      = 12;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FILL    = 2'd1,
    ST_PROCESS = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // Zero-extends an unsigned pixel into the signed gradient width.
  function automatic logic signed [GRAD_W-1:0] widen(input logic [COLOR_SIZE-1:0] p);
    return $signed({{(GRAD_W-COLOR_SIZE){1'b0}}, p});
  endfunction

  // Absolute value of a gradient; the largest magnitude (1020) fits in GRAD_W bits.
  function automatic logic [GRAD_W-1:0] magnitude(input logic signed [GRAD_W-1:0] g);
    return g[GRAD_W-1] ? $unsigned(-g) : $unsigned(g);
  endfunction

  // Clamps the gradient sum to the largest displayable pixel value.
  function automatic logic [COLOR_SIZE-1:0] saturate(input logic [SUM_W-1:0] v);
    return (v > SUM_W'(255)) ? COLOR_SIZE'(255) : v[COLOR_SIZE-1:0];
  endfunction

endpackage

// File: rtl/line_buffer.sv
// One image row of pixel delay: a shift register that advances only when enabled.
module line_buffer #(
  parameter int COLOR_SIZE = sobel_pkg::COLOR_SIZE,
  parameter int DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  enable,
  input  logic [COLOR_SIZE-1:0] data_in,
  output logic [COLOR_SIZE-1:0] data_out
);

  logic [COLOR_SIZE-1:0] mem [DEPTH];

  // Shift one position per accepted pixel; contents are never cleared.
  always_ff @(posedge clk) begin
    if (enable) begin
      mem[0] <= data_in;
      for (int i = 1; i < DEPTH; i++) begin
        mem[i] <= mem[i-1];
      end
    end
  end

  assign data_out = mem[DEPTH-1];

endmodule

// File: rtl/sobel_filter.sv
// Streaming 3x3 Sobel edge filter: two line buffers feed a sliding window,
// |Gx|+|Gy| is saturated to 8 bits and presented through a valid/ready output register.
module sobel_filter
  import sobel_pkg::*;
#(
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  Start_i,
  input  logic                  GrayValid_i,
  input  logic [COLOR_SIZE-1:0] GrayColor_i,
  output logic                  GrayReady_o,
  output logic                  EdgeValid_o,
  output logic [COLOR_SIZE-1:0] EdgeColor_o,
  input  logic                  EdgeReady_i,
  output logic                  Done_o
);

  localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

  state_t state, next_state;

  logic [COL_W-1:0]      col;
  logic [ROW_W-1:0]      row;
  logic                  gray_ready;
  logic                  accept;
  logic                  emit;
  logic                  last_fill;
  logic                  last_frame;
  logic                  edge_valid;
  logic [COLOR_SIZE-1:0] edge_color;
  logic                  done;
  logic [COLOR_SIZE-1:0] prev_row;
  logic [COLOR_SIZE-1:0] prev2_row;
  logic [COLOR_SIZE-1:0] win      [3][3];
  logic [COLOR_SIZE-1:0] win_next [3][3];
  logic signed [GRAD_W-1:0] gx;
  logic signed [GRAD_W-1:0] gy;
  logic [SUM_W-1:0]         grad_sum;

  assign accept     = GrayValid_i && gray_ready;
  assign last_fill  = accept && (row == ROW_W'(1)) && (col == COL_LAST);
  assign last_frame = accept && (row == ROW_LAST) && (col == COL_LAST);
  assign emit       = accept && (row >= ROW_W'(2)) && (col >= COL_W'(2));

  line_buffer #(.COLOR_SIZE(COLOR_SIZE), .DEPTH(IMG_WIDTH)) u_line0 (
    .clk      (clk_i),
    .enable   (accept),
    .data_in  (GrayColor_i),
    .data_out (prev_row)
  );

  line_buffer #(.COLOR_SIZE(COLOR_SIZE), .DEPTH(IMG_WIDTH)) u_line1 (
    .clk      (clk_i),
    .enable   (accept),
    .data_in  (prev_row),
    .data_out (prev2_row)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_i) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next-state logic; Start_i only matters while idle.
  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE:    if (Start_i)     next_state = ST_FILL;
      ST_FILL:    if (last_fill)   next_state = ST_PROCESS;
      ST_PROCESS: if (last_frame)  next_state = ST_DONE;
      ST_DONE:    if (!edge_valid) next_state = ST_IDLE;
      default:                     next_state = ST_IDLE;
    endcase
  end

  // FSM outputs: pixel acceptance while streaming and the end-of-frame pulse.
  always_comb begin
    gray_ready = 1'b0;
    done       = 1'b0;
    unique case (state)
      ST_FILL, ST_PROCESS: gray_ready = !edge_valid || EdgeReady_i;
      ST_DONE:             done       = !edge_valid;
      default: ;
    endcase
  end

  // Raster position of the next pixel, restarted whenever a frame begins.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      col <= '0;
      row <= '0;
    end else if (state == ST_IDLE && Start_i) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  // Window as it will look once the incoming pixel shifts in: rows top to bottom, newest column on the right.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      win_next[r][0] = win[r][1];
      win_next[r][1] = win[r][2];
    end
    win_next[0][2] = prev2_row;
    win_next[1][2] = prev_row;
    win_next[2][2] = GrayColor_i;
  end

  // Slide the window one column per accepted pixel.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win[r][c] <= win_next[r][c];
        end
      end
    end
  end

  // Sobel gradients on the post-shift window so the result registers in the accepting cycle.
  always_comb begin
    gx = (widen(win_next[0][2]) + (widen(win_next[1][2]) <<< 1) + widen(win_next[2][2]))
       - (widen(win_next[0][0]) + (widen(win_next[1][0]) <<< 1) + widen(win_next[2][0]));
    gy = (widen(win_next[2][0]) + (widen(win_next[2][1]) <<< 1) + widen(win_next[2][2]))
       - (widen(win_next[0][0]) + (widen(win_next[0][1]) <<< 1) + widen(win_next[0][2]));
    grad_sum = SUM_W'(magnitude(gx)) + SUM_W'(magnitude(gy));
  end

  // Output register: loads on every interior pixel, holds under backpressure, clears on handoff.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      edge_valid <= 1'b0;
      edge_color <= '0;
    end else if (emit) begin
      edge_valid <= 1'b1;
      edge_color <= saturate(grad_sum);
    end else if (edge_valid && EdgeReady_i) begin
      edge_valid <= 1'b0;
    end
  end

  assign GrayReady_o = gray_ready;
  assign EdgeValid_o = edge_valid;
  assign EdgeColor_o = edge_color;
  assign Done_o      = done;

endmodule
